// File: rtl/knn_pkg.sv
// Shared types and constants for the kNN distance datapath.
package knn_pkg;

  localparam int DIM    = 4;
  localparam int ELEM_W = 8;
  localparam int ADDR_W = 8;
  localparam int DIST_W = 32;

  typedef logic signed [ELEM_W-1:0] elem_t;
  typedef elem_t [DIM-1:0]          point_t;
  typedef logic [DIST_W-1:0]        dist_t;
  typedef logic [ADDR_W-1:0]        addr_t;
  typedef logic [ADDR_W:0]          cnt_t;

  // Result record consumed by the k-th-smallest tracker.
  typedef struct packed {
    dist_t distance;
    addr_t addr;
  } dist_addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/knn_sq_dist.sv
// Combinational squared Euclidean distance between two points.
module knn_sq_dist
  import knn_pkg::*;
(
  input  point_t query,
  input  point_t sample,
  output dist_t  distance
);

  localparam int DIFF_W = ELEM_W + 1;
  localparam int SQ_W   = 2 * ELEM_W + 2;

  // Per-element signed difference, squared, accumulated zero-extended.
  always_comb begin
    logic signed [DIFF_W-1:0] diff;
    logic signed [SQ_W-1:0]   prod;
    distance = '0;
    diff     = '0;
    prod     = '0;
    for (int i = 0; i < DIM; i++) begin
      diff     = DIFF_W'($signed(query[i])) - DIFF_W'($signed(sample[i]));
      prod     = SQ_W'(diff) * SQ_W'(diff);
      distance = distance + DIST_W'($unsigned(prod));
    end
  end

endmodule

// File: rtl/knn_distance_streamer.sv
// Streams {distance, addr} for every stored point against a latched query.
//
// state  | meaning
// IDLE   | waiting for a query; query_ready high
// SCAN   | issuing SRAM reads and delivering results in address order
// FINISH | one-cycle finish pulse, then back to IDLE
module knn_distance_streamer
  import knn_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_query_valid,
  input  logic [DIM*ELEM_W-1:0]    io_query_bits,
  input  logic [ADDR_W:0]          io_query_numPoints,
  output logic                     io_query_ready,
  output logic                     io_memReq_valid,
  output logic [ADDR_W-1:0]        io_memReq_addr,
  input  logic [DIM*ELEM_W-1:0]    io_memResp_data,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [DIST_W-1:0]        io_out_bits_distance,
  output logic [ADDR_W-1:0]        io_out_bits_addr,
  output logic                     io_finish,
  output logic                     io_busy
);

  state_t     state_q, state_d;
  point_t     query_q;
  cnt_t       num_q;
  cnt_t       idx_q;
  logic       inflight_q;
  addr_t      req_addr_q;
  logic       out_valid_q;
  dist_addr_t out_q;

  dist_t      dist_w;
  logic       query_fire;
  logic       out_fire;
  logic       issue;
  logic       last_fire;
  cnt_t       last_addr;

  knn_sq_dist u_sq_dist (
    .query    (query_q),
    .sample   (point_t'(io_memResp_data)),
    .distance (dist_w)
  );

  // Handshake and request-issue qualifiers.
  always_comb begin
    query_fire = (state_q == IDLE) && io_query_valid;
    out_fire   = out_valid_q && io_out_ready;
    last_addr  = num_q - cnt_t'(1);
    last_fire  = out_fire && (cnt_t'(out_q.addr) == last_addr);
    issue      = (state_q == SCAN) && (idx_q < num_q) && !inflight_q
                 && (!out_valid_q || out_fire);
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d         = state_q;
    io_query_ready  = 1'b0;
    io_finish       = 1'b0;
    io_busy         = 1'b0;
    case (state_q)
      IDLE: begin
        io_query_ready = 1'b1;
        if (io_query_valid) begin
          state_d = (io_query_numPoints == '0) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        io_busy = 1'b1;
        if (last_fire) state_d = FINISH;
      end
      FINISH: begin
        io_busy   = 1'b1;
        io_finish = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, scan bookkeeping and the output holding register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      query_q     <= '0;
      num_q       <= '0;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
      req_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q <= state_d;
      if (query_fire) begin
        query_q <= point_t'(io_query_bits);
        num_q   <= io_query_numPoints;
        idx_q   <= '0;
      end
      if (issue) begin
        idx_q      <= idx_q + cnt_t'(1);
        req_addr_q <= idx_q[ADDR_W-1:0];
        inflight_q <= 1'b1;
      end else if (inflight_q) begin
        inflight_q <= 1'b0;
      end
      // The register is always empty while a response is in flight.
      if (inflight_q) begin
        out_valid_q    <= 1'b1;
        out_q.distance <= dist_w;
        out_q.addr     <= req_addr_q;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign io_memReq_valid      = issue;
  assign io_memReq_addr       = idx_q[ADDR_W-1:0];
  assign io_out_valid         = out_valid_q;
  assign io_out_bits_distance = out_q.distance;
  assign io_out_bits_addr     = out_q.addr;

endmodule

// File: tb/tb_knn_distance_streamer.sv
// Randomized and directed bench for the kNN distance streamer.
module tb_knn_distance_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_query_valid;
  logic [31:0] io_query_bits;
  logic [8:0]  io_query_numPoints;
  logic        io_query_ready;
  logic        io_memReq_valid;
  logic [7:0]  io_memReq_addr;
  logic [31:0] io_memResp_data;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_bits_distance;
  logic [7:0]  io_out_bits_addr;
  logic        io_finish;
  logic        io_busy;

  knn_distance_streamer dut (
    .clock                (clock),
    .reset                (reset),
    .io_query_valid       (io_query_valid),
    .io_query_bits        (io_query_bits),
    .io_query_numPoints   (io_query_numPoints),
    .io_query_ready       (io_query_ready),
    .io_memReq_valid      (io_memReq_valid),
    .io_memReq_addr       (io_memReq_addr),
    .io_memResp_data      (io_memResp_data),
    .io_out_valid         (io_out_valid),
    .io_out_ready         (io_out_ready),
    .io_out_bits_distance (io_out_bits_distance),
    .io_out_bits_addr     (io_out_bits_addr),
    .io_finish            (io_finish),
    .io_busy              (io_busy)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] mem [256];
  logic [31:0] cur_query;
  int          exp_idx, exp_num;
  int          hs_count = 0, fin_count = 0, req_count = 0;
  int          first_seen, first_valid_cyc, last_hs_cyc, fin_cyc, fire_cyc;
  int          got_dist [256];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dist;
  logic [7:0]  prev_addr;
  logic        rand_ready = 1'b0;
  logic        force_low = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Reference: plain integer sum of squared element differences.
  function automatic int ref_dist(input logic [31:0] q, input logic [31:0] p);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      int d = int'($signed(q[i*8 +: 8])) - int'($signed(p[i*8 +: 8]));
      s += d * d;
    end
    return s;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous SRAM: data one cycle after a read, garbage otherwise.
  always @(posedge clock)
    io_memResp_data <= io_memReq_valid ? mem[io_memReq_addr] : $urandom;

  always @(posedge clock) begin
    #2;
    io_out_ready = force_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Output monitor / scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (io_memReq_valid) req_count++;
      if (io_out_valid && first_seen == 0) begin
        first_seen = 1;
        first_valid_cyc = cyc;
      end
      if (prev_stall) begin
        check("hold_valid", io_out_valid, 1);
        check("hold_dist", io_out_bits_distance, prev_dist);
        check("hold_addr", io_out_bits_addr, prev_addr);
      end
      if (io_out_valid && !io_out_ready) check("stall_noreq", io_memReq_valid, 0);
      if (io_out_valid && io_out_ready) begin
        check("out_addr", io_out_bits_addr, exp_idx % 256);
        check("out_dist", io_out_bits_distance, ref_dist(cur_query, mem[exp_idx % 256]));
        got_dist[exp_idx % 256] = int'(io_out_bits_distance);
        exp_idx++;
        hs_count++;
        last_hs_cyc = cyc;
      end
      if (io_finish) begin
        check("fin_no_valid", io_out_valid, 0);
        check("fin_all_delivered", exp_idx, exp_num);
        fin_count++;
        fin_cyc = cyc;
      end
      prev_stall = io_out_valid && !io_out_ready;
      prev_dist  = io_out_bits_distance;
      prev_addr  = io_out_bits_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_query(input logic [31:0] q, input int n);
    cur_query  = q;
    exp_num    = n;
    exp_idx    = 0;
    first_seen = 0;
    req_count  = 0;
    io_query_valid     = 1'b1;
    io_query_bits      = q;
    io_query_numPoints = 9'(n);
    @(posedge clock);
    #1;
    fire_cyc = cyc;
    io_query_valid = 1'b0;
    io_query_bits  = $urandom;
  endtask

  task automatic wait_finish(input int n);
    int f0 = fin_count;
    for (int i = 0; i < 8 * n + 40; i++) begin
      @(posedge clock);
      #1;
      if (fin_count != f0) break;
    end
    check("finish_seen", fin_count - f0, 1);
  endtask

  task automatic run_query(input logic [31:0] q, input int n);
    start_query(q, n);
    wait_finish(n);
    check("delivered", exp_idx, n);
    if (n > 0) begin
      check("lat_first_valid", first_valid_cyc - fire_cyc, 2);
      check("lat_finish", fin_cyc - last_hs_cyc, 1);
    end
    @(posedge clock);
    #1;
    check("ready_after_finish", io_query_ready, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_qready"}, io_query_ready, 1);
    check({tag, "_memreq"}, io_memReq_valid, 0);
    check({tag, "_oval"}, io_out_valid, 0);
    check({tag, "_odist"}, io_out_bits_distance, 0);
    check({tag, "_oaddr"}, io_out_bits_addr, 0);
    check({tag, "_finish"}, io_finish, 0);
    check({tag, "_busy"}, io_busy, 0);
  endtask

  initial begin
    int n, h0, f0;
    reset = 1'b1;
    io_query_valid = 1'b0;
    io_query_bits = '0;
    io_query_numPoints = '0;
    io_out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed: three known points.
    mem[0] = pack(1, 2, 3, 4);
    mem[1] = pack(0, 0, 0, 0);
    mem[2] = pack(-1, -2, -3, -4);
    run_query(pack(1, 2, 3, 4), 3);
    check("t1_d0", got_dist[0], 0);
    check("t1_d1", got_dist[1], 30);
    check("t1_d2", got_dist[2], 120);

    // Extreme difference.
    mem[0] = pack(-128, -128, -128, -128);
    run_query(pack(127, 127, 127, 127), 1);
    check("max_dist", got_dist[0], 260100);

    // Backpressure on the first result.
    mem[0] = pack(1, 2, 3, 4);
    mem[1] = pack(0, 0, 0, 0);
    mem[2] = pack(-1, -2, -3, -4);
    force_low = 1'b1;
    start_query(pack(1, 2, 3, 4), 3);
    for (int i = 0; i < 20 && !io_out_valid; i++) begin
      @(posedge clock);
      #1;
    end
    check("stall_valid_seen", io_out_valid, 1);
    repeat (5) @(posedge clock);
    #1;
    check("stall_req_count", req_count, 1);
    check("stall_dist", io_out_bits_distance, 0);
    force_low = 1'b0;
    wait_finish(3);
    check("stall_delivered", exp_idx, 3);
    check("stall_d2", got_dist[2], 120);

    // Empty scan.
    @(posedge clock);
    #1;
    start_query($urandom, 0);
    wait_finish(0);
    check("empty_fin_lat", fin_cyc - fire_cyc, 0);
    check("empty_req", req_count, 0);
    check("empty_first_valid", first_seen, 0);
    @(posedge clock);
    #1;
    check("empty_ready_again", io_query_ready, 1);

    // Query during scan is ignored; reset mid-scan drops everything.
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    h0 = hs_count;
    f0 = fin_count;
    start_query($urandom, 6);
    io_query_valid = 1'b1;
    io_query_bits = $urandom;
    io_query_numPoints = 9'd1;
    check("scan_qready", io_query_ready, 0);
    for (int i = 0; i < 30 && hs_count - h0 < 2; i++) begin
      @(posedge clock);
      #1;
    end
    io_query_valid = 1'b0;
    check("pre_reset_hs", hs_count - h0, 2);
    h0 = hs_count;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_idle_outputs("midreset");
    reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("midreset_no_finish", fin_count - f0, 0);
    check("midreset_no_out", hs_count - h0, 0);
    run_query($urandom, 2);

    // Random scans with random backpressure.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) mem[i] = $urandom;
      rand_ready = 1'($urandom_range(0, 1));
      run_query($urandom, n);
    end
    rand_ready = 1'b0;

    // Full address space.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    f0 = fin_count;
    run_query($urandom, 256);
    check("full_one_finish", fin_count - f0, 1);
    check("full_time_ok", int'((fin_cyc - fire_cyc) >= 510 && (fin_cyc - fire_cyc) <= 514), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
